data_buffer: RTL and testbench

DATA_BUFFER -- requirements
Module: data_buffer

---
 rtl/data_buffer.sv | 160 ++++++++++++++++
 tb/tb_data_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_buffer.sv
// 64-byte circular buffer between the AHB slave side (1/2/4-byte accesses)
// and the USB packet side (single bytes), with occupancy and error pulses.
module data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        flush,
  input  logic        storeTxData,
  input  logic [31:0] txData,
  input  logic [1:0]  dataSize,
  input  logic        getRxData,
  output logic [31:0] rxData,
  input  logic        storeRxPacketData,
  input  logic [7:0]  rxPacketData,
  input  logic        getTxPacketData,
  output logic [7:0]  txPacketData,
  output logic [6:0]  bufferOccupancy,
  output logic        overflowErr,
  output logic        underflowErr
);

  localparam logic [6:0] CAPACITY = 7'(DEPTH);

  logic [7:0] r_mem [64];
  logic [5:0] r_wrPtr;
  logic [5:0] r_rdPtr;
  logic [6:0] r_occ;
  logic       r_ovf;
  logic       r_unf;

  logic [2:0] w_ahbSize;
  logic       w_sizeIllegal;
  logic [6:0] w_free;

  logic       w_wrReq;
  logic       w_wrFromAhb;
  logic       w_wrConflict;
  logic [2:0] w_wrSize;
  logic       w_wrOk;
  logic [2:0] w_wrCnt;

  logic       w_rdReq;
  logic       w_rdConflict;
  logic [2:0] w_rdSize;
  logic       w_rdOk;
  logic [2:0] w_rdCnt;

  logic       w_ovfNext;
  logic       w_unfNext;
  logic [7:0] w_wrByte [4];
  logic [7:0] w_rdByte [4];

  always_comb begin
    w_sizeIllegal = 1'b0;
    case (dataSize)
      2'b00:   w_ahbSize = 3'd1;
      2'b01:   w_ahbSize = 3'd2;
      2'b10:   w_ahbSize = 3'd4;
      default: begin
        w_ahbSize     = 3'd0;
        w_sizeIllegal = 1'b1;
      end
    endcase
  end

  assign w_free = CAPACITY - r_occ;

  // The AHB strobe always wins a same-cycle collision; the loser is reported as an error.
  always_comb begin
    w_wrReq      = 1'b0;
    w_wrFromAhb  = 1'b0;
    w_wrConflict = 1'b0;
    w_wrSize     = 3'd0;
    w_wrOk       = 1'b0;
    if (storeTxData) begin
      w_wrReq      = 1'b1;
      w_wrFromAhb  = 1'b1;
      w_wrConflict = storeRxPacketData;
      w_wrSize     = w_ahbSize;
      w_wrOk       = !w_sizeIllegal && ({4'b0, w_ahbSize} <= w_free);
    end else if (storeRxPacketData) begin
      w_wrReq  = 1'b1;
      w_wrSize = 3'd1;
      w_wrOk   = (w_free != 7'd0);
    end
  end

  always_comb begin
    w_rdReq      = 1'b0;
    w_rdConflict = 1'b0;
    w_rdSize     = 3'd0;
    w_rdOk       = 1'b0;
    if (getRxData) begin
      w_rdReq      = 1'b1;
      w_rdConflict = getTxPacketData;
      w_rdSize     = w_ahbSize;
      w_rdOk       = !w_sizeIllegal && ({4'b0, w_ahbSize} <= r_occ);
    end else if (getTxPacketData) begin
      w_rdReq  = 1'b1;
      w_rdSize = 3'd1;
      w_rdOk   = (r_occ != 7'd0);
    end
  end

  assign w_wrCnt   = (!flush && w_wrReq && w_wrOk) ? w_wrSize : 3'd0;
  assign w_rdCnt   = (!flush && w_rdReq && w_rdOk) ? w_rdSize : 3'd0;
  assign w_ovfNext = !flush && ((w_wrReq && !w_wrOk) || w_wrConflict);
  assign w_unfNext = !flush && ((w_rdReq && !w_rdOk) || w_rdConflict);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_wrByte[k] = w_wrFromAhb ? txData[8*k +: 8] : rxPacketData;
      w_rdByte[k] = r_mem[r_rdPtr + 6'(k)];
    end
  end

  // Storage carries no reset; pointer arithmetic on 6 bits gives the 63->0 wrap.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_wrCnt) begin
        r_mem[r_wrPtr + 6'(k)] <= w_wrByte[k];
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wrPtr <= 6'd0;
      r_rdPtr <= 6'd0;
      r_occ   <= 7'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (flush) begin
      r_wrPtr <= 6'd0;
      r_rdPtr <= 6'd0;
      r_occ   <= 7'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wrPtr <= r_wrPtr + {3'b0, w_wrCnt};
      r_rdPtr <= r_rdPtr + {3'b0, w_rdCnt};
      r_occ   <= r_occ + {4'b0, w_wrCnt} - {4'b0, w_rdCnt};
      r_ovf   <= w_ovfNext;
      r_unf   <= w_unfNext;
    end
  end

  assign rxData = {
    dataSize[1]            ? w_rdByte[3] : 8'h00,
    dataSize[1]            ? w_rdByte[2] : 8'h00,
    (dataSize != 2'b00)    ? w_rdByte[1] : 8'h00,
    w_rdByte[0]
  };
  assign txPacketData    = w_rdByte[0];
  assign bufferOccupancy = r_occ;
  assign overflowErr     = r_ovf;
  assign underflowErr    = r_unf;

endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer: directed scenarios with literal
// expectations, then randomized traffic against a byte-queue model.
module tb_data_buffer;

  logic        clk;
  logic        nRst;
  logic        flush;
  logic        storeTxData;
  logic [31:0] txData;
  logic [1:0]  dataSize;
  logic        getRxData;
  logic [31:0] rxData;
  logic        storeRxPacketData;
  logic [7:0]  rxPacketData;
  logic        getTxPacketData;
  logic [7:0]  txPacketData;
  logic [6:0]  bufferOccupancy;
  logic        overflowErr;
  logic        underflowErr;

  int nVectors = 0;
  int nCompares = 0;
  int nMiscompares = 0;
  byte unsigned q[$];

  data_buffer #(.DEPTH(64)) dut (
    .clk(clk),
    .nRst(nRst),
    .flush(flush),
    .storeTxData(storeTxData),
    .txData(txData),
    .dataSize(dataSize),
    .getRxData(getRxData),
    .rxData(rxData),
    .storeRxPacketData(storeRxPacketData),
    .rxPacketData(rxPacketData),
    .getTxPacketData(getTxPacketData),
    .txPacketData(txPacketData),
    .bufferOccupancy(bufferOccupancy),
    .overflowErr(overflowErr),
    .underflowErr(underflowErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompares++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    flush = 1'b0; storeTxData = 1'b0; storeRxPacketData = 1'b0;
    getRxData = 1'b0; getTxPacketData = 1'b0; dataSize = 2'b00;
    txData = 32'h0; rxPacketData = 8'h0;
  endtask

  // One clock of stimulus: model decides acceptance from the queue length,
  // data outputs are checked mid-cycle, registered outputs just after the edge.
  task automatic applyStimulus(input bit fl, input bit sTx, input bit sRx, input bit gRx,
                               input bit gTx, input bit [1:0] ds, input bit [31:0] td,
                               input bit [7:0] rp);
    int occ, rdN, wrN, n;
    bit rdAhb, expOv, expUn;
    logic [31:0] e;
    @(negedge clk);
    flush = fl; storeTxData = sTx; storeRxPacketData = sRx; getRxData = gRx;
    getTxPacketData = gTx; dataSize = ds; txData = td; rxPacketData = rp;
    #1;
    nVectors++;
    occ = q.size(); rdN = 0; wrN = 0; rdAhb = 0; expOv = 0; expUn = 0;
    if (!fl) begin
      if (gRx) begin
        if (gTx) expUn = 1;
        if (ds == 2'b11) expUn = 1;
        else begin
          n = 1 << ds;
          if (n <= occ) begin rdN = n; rdAhb = 1; end
          else expUn = 1;
        end
      end else if (gTx) begin
        if (occ >= 1) rdN = 1; else expUn = 1;
      end
      if (sTx) begin
        if (sRx) expOv = 1;
        if (ds == 2'b11) expOv = 1;
        else begin
          n = 1 << ds;
          if (n <= 64 - occ) wrN = n; else expOv = 1;
        end
      end else if (sRx) begin
        if (occ < 64) wrN = 1; else expOv = 1;
      end
    end
    if (rdN > 0 && rdAhb) begin
      e = 32'h0;
      for (int k = 0; k < rdN; k++) e = e | (32'(q[k]) << (8 * k));
      checkOutput("rxData", rxData, e);
    end else if (rdN > 0) begin
      checkOutput("txPacketData", {24'h0, txPacketData}, {24'h0, q[0]});
    end
    if (fl) q.delete();
    repeat (rdN) void'(q.pop_front());
    for (int k = 0; k < wrN; k++) q.push_back(sTx ? td[8*k +: 8] : rp);
    @(posedge clk);
    #1;
    checkOutput("occupancy", {25'h0, bufferOccupancy}, 32'(q.size()));
    checkOutput("overflowErr", {31'h0, overflowErr}, {31'h0, expOv});
    checkOutput("underflowErr", {31'h0, underflowErr}, {31'h0, expUn});
    clearInputs();
  endtask

  task automatic pushWord(input bit [31:0] w);
    applyStimulus(0, 1, 0, 0, 0, 2'b10, w, 8'h0);
  endtask

  task automatic pushByte(input bit [7:0] b);
    applyStimulus(0, 0, 1, 0, 0, 2'b00, 32'h0, b);
  endtask

  task automatic popByte();
    applyStimulus(0, 0, 0, 0, 1, 2'b00, 32'h0, 8'h0);
  endtask

  task automatic popAhb(input bit [1:0] ds);
    applyStimulus(0, 0, 0, 1, 0, ds, 32'h0, 8'h0);
  endtask

  // Asserted between clock edges so the clear is observed without any edge.
  task automatic resetPulse();
    #2;
    nRst = 1'b0;
    #1;
    checkOutput("rst_occupancy", {25'h0, bufferOccupancy}, 32'd0);
    checkOutput("rst_overflowErr", {31'h0, overflowErr}, 32'd0);
    checkOutput("rst_underflowErr", {31'h0, underflowErr}, 32'd0);
    q.delete();
    @(negedge clk);
    nRst = 1'b1;
  endtask

  initial begin
    bit fl, sTx, sRx, gRx, gTx;
    bit [1:0] ds;
    int wrPct;

    clearInputs();
    nRst = 1'b0;
    #1;
    checkOutput("init_occupancy", {25'h0, bufferOccupancy}, 32'd0);
    checkOutput("init_overflowErr", {31'h0, overflowErr}, 32'd0);
    checkOutput("init_underflowErr", {31'h0, underflowErr}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;

    pushWord(32'h44332211);
    checkOutput("w4_occ", {25'h0, bufferOccupancy}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("w4_head", {24'h0, txPacketData}, 32'h11 * (i + 1));
      popByte();
      checkOutput("w4_occ_drain", {25'h0, bufferOccupancy}, 32'(3 - i));
    end

    for (int i = 0; i < 16; i++) pushByte(8'(i));
    checkOutput("b16_occ", {25'h0, bufferOccupancy}, 32'd16);
    dataSize = 2'b10;
    #1;
    checkOutput("b16_word", rxData, 32'h03020100);
    popAhb(2'b10);
    checkOutput("b16_occ_after", {25'h0, bufferOccupancy}, 32'd12);
    dataSize = 2'b00;
    #1;
    checkOutput("b16_byte_mask", rxData, 32'h00000004);

    resetPulse();
    for (int i = 0; i < 16; i++) pushWord($urandom);
    checkOutput("full_occ", {25'h0, bufferOccupancy}, 32'd64);
    pushByte(8'hA5);
    checkOutput("full_ovf", {31'h0, overflowErr}, 32'd1);
    checkOutput("full_occ_kept", {25'h0, bufferOccupancy}, 32'd64);
    popByte();
    checkOutput("ovf_one_cycle", {31'h0, overflowErr}, 32'd0);
    for (int i = 0; i < 15; i++) popAhb(2'b10);
    repeat (2) popByte();
    checkOutput("one_left", {25'h0, bufferOccupancy}, 32'd1);
    popAhb(2'b01);
    checkOutput("half_unf", {31'h0, underflowErr}, 32'd1);
    checkOutput("half_unf_occ", {25'h0, bufferOccupancy}, 32'd1);

    resetPulse();
    for (int i = 0; i < 8; i++) pushByte(8'(i + 8'h40));
    applyStimulus(0, 1, 0, 0, 1, 2'b10, 32'hCAFEF00D, 8'h0);
    checkOutput("rw_same_occ", {25'h0, bufferOccupancy}, 32'd11);

    resetPulse();
    for (int i = 0; i < 62; i++) begin
      pushByte(8'(i));
      popByte();
    end
    pushWord(32'hDDCCBBAA);
    dataSize = 2'b10;
    #1;
    checkOutput("wrap_word", rxData, 32'hDDCCBBAA);
    popAhb(2'b10);
    checkOutput("wrap_occ", {25'h0, bufferOccupancy}, 32'd0);

    for (int i = 0; i < 5; i++) pushWord(32'h01020304 + 32'(i));
    checkOutput("pre_flush_occ", {25'h0, bufferOccupancy}, 32'd20);
    applyStimulus(1, 1, 0, 0, 0, 2'b10, 32'h12345678, 8'h0);
    checkOutput("flush_occ", {25'h0, bufferOccupancy}, 32'd0);
    checkOutput("flush_ovf", {31'h0, overflowErr}, 32'd0);
    pushByte(8'h77);
    checkOutput("post_flush_head", {24'h0, txPacketData}, 32'h77);
    pushWord(32'h11111111);
    resetPulse();
    pushByte(8'h5A);
    checkOutput("post_rst_head", {24'h0, txPacketData}, 32'h5A);

    wrPct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) wrPct = (wrPct == 60) ? 30 : 60;
      if ($urandom_range(0, 299) == 0) resetPulse();
      fl  = ($urandom_range(0, 99) == 0);
      sTx = ($urandom_range(0, 99) < wrPct / 2);
      sRx = ($urandom_range(0, 99) < wrPct / 2);
      gRx = ($urandom_range(0, 99) < (90 - wrPct) / 2);
      gTx = ($urandom_range(0, 99) < (90 - wrPct) / 2);
      ds  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(fl, sTx, sRx, gRx, gTx, ds, $urandom, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
